mem_responder: RTL and testbench
================================

# mem_responder

Responder end of the CPU native memory bus (mem_valid / mem_ready handshake): accepts one request at a time from the core and services it against a single-port 32-bit sky130 OpenRAM macro (sram_32_32_sky130A style). Partial-word stores are implemented as read-modify-write, because the macro has no byte mask. Out-of-range and forbidden accesses are completed safely and flagged. One instance fronts the instruction SRAM (READ_ONLY=1); another fronts the data SRAM.

## Interface
- DATA_WIDTH, 32: bus and SRAM word width; only 32 is supported.
- ADDR_WIDTH, 5: number of word-index bits; RAM_DEPTH = 1 << ADDR_WIDTH words.
- SRAM_AW, 6: SRAM address port width; upper bits above ADDR_WIDTH are tied to 0.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.
- READ_ONLY, 0: when 1, all writes are dropped and flagged.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- resetn  in  1  reset, synchronous, active-low.
- mem_valid  in  1  request present; held by the core until mem_ready.
- mem_instr  in  1  fetch qualifier; no effect on behaviour.
- mem_addr  in  32  byte address; bits [1:0] ignored.
- mem_wdata  in  32  store data.
- mem_wstrb  in  4  byte enables; 0 = read.
- mem_ready  out  1  one-cycle completion pulse.
- mem_rdata  out  32  read data; valid when mem_ready=1.
- err  out  1  sticky error flag.
- sram_csb  out  1  chip select, active-low.
- sram_web  out  1  write enable, active-low.
- sram_addr  out  SRAM_AW  word address.
- sram_din  out  32  write data.
- sram_dout  in  32  read data; valid in the cycle after the read-issuing edge.

## Operation
- Word index: idx = (mem_addr - BASE_ADDR) >> 2. The access is in range iff bits [31:ADDR_WIDTH+2] of (mem_addr - BASE_ADDR) are all zero.
- State machine: IDLE, RD, RMW, DONE.
- IDLE:
  - No mem_valid: sram_csb=1, sram_web=1.
  - mem_valid with out-of-range address, or a write with READ_ONLY=1: SRAM untouched; set err; go to DONE. If the access is a read, load mem_rdata=0.
  - Read (wstrb=0): csb=0, web=1, addr=idx; go to RD.
  - Full write (wstrb=4'hF): csb=0, web=0, din=mem_wdata; go to DONE.
  - Partial write (any other wstrb): issue a read of idx; go to RMW.
- RD: SRAM idle. Register mem_rdata <= sram_dout. Go to DONE.
- RMW:
  - csb=0, web=0, addr=idx.
  - din byte k = mem_wstrb[k] ? mem_wdata byte k : sram_dout byte k.
  - Go to DONE.
- DONE: mem_ready=1; SRAM idle; go to IDLE unconditionally. IDLE never samples mem_valid during the cycle mem_ready is high, so there is no double acceptance.
- mem_rdata holds its value between reads; writes do not change it.
- err stays set until reset.
- If mem_valid drops mid-transaction (protocol violation), the transaction still completes, DONE still pulses, and any write still occurs.
- SRAM control outputs are decoded combinationally from state and request.

## Timing
- Reset (resetn low at an edge): state=IDLE, mem_ready=0, mem_rdata=0, err=0.
- While resetn=0, sram_csb=1 and sram_web=1 are forced combinationally. A reset during RMW therefore aborts the write-back; no partial write occurs.
- Latency, counting from the edge E at which IDLE sees mem_valid:
  - Read: mem_ready high in the cycle after E+1.
  - Full write: mem_ready high in the cycle after E.
  - Partial write: write at E+1; mem_ready high in the cycle after E+1.
  - Error: mem_ready high in the cycle after E.
- mem_ready is exactly 1 cycle wide and is driven from the state register only.
- Minimum spacing between back-to-back requests is 1 IDLE cycle.

## Test plan
- Full write, then read: write 0xDEADBEEF to 0x0C (wstrb=F), then read 0x0C. Required: write mem_ready 1 cycle after acceptance; read returns 0xDEADBEEF with mem_ready 2 edges after acceptance; err=0.
- Byte merge: word 0x10 = 0x11223344; write wdata=0xAABBCCDD with wstrb=4'b0101. Required: readback 0x11BB33DD; sram_web low for exactly one cycle (the RMW cycle).
- Out of range: ADDR_WIDTH=5, read 0x80. Required: mem_rdata=0, mem_ready 1 cycle after acceptance, err=1 sticky, sram_csb stays 1. A subsequent valid read succeeds with err still 1.
- READ_ONLY=1: store 0x12345678 to 0x04. Required: err=1; a subsequent read of 0x04 returns the preloaded contents, unchanged.
- Back-to-back: 8 reads with mem_valid held continuously, core-style. Required: exactly 8 mem_ready pulses, each 1 cycle wide, with correct data and no duplicated accesses.
- Reset during RMW: assert resetn=0 in the RMW cycle of a wstrb=4'b0001 store. Required: the target word is unchanged, mem_ready=0, err=0, state=IDLE.

Source files
------------

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - mem_valid/mem_ready responder over a single-port SRAM macro
// Byte stores become read-modify-write because the macro has no byte mask.
module mem_responder #(
   parameter int          DATA_WIDTH = 32,
   parameter int          ADDR_WIDTH = 5,
   parameter int          SRAM_AW    = 6,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter bit          READ_ONLY  = 1'b0
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    mem_valid,
   input  logic                    mem_instr,
   input  logic [31:0]             mem_addr,
   input  logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic [DATA_WIDTH/8-1:0] mem_wstrb,
   output logic                    mem_ready,
   output logic [DATA_WIDTH-1:0]   mem_rdata,
   output logic                    err,
   output logic                    sram_csb,
   output logic                    sram_web,
   output logic [SRAM_AW-1:0]      sram_addr,
   output logic [DATA_WIDTH-1:0]   sram_din,
   input  logic [DATA_WIDTH-1:0]   sram_dout
);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_RMW, S_DONE} state_t;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    err_q, err_d;

   logic [31:0]             offset;
   logic [ADDR_WIDTH-1:0]   idx;
   logic                    in_range;
   logic                    is_read;
   logic                    is_full;
   logic                    reject;
   logic [DATA_WIDTH-1:0]   merged;
   logic                    unused_ok;

   assign offset    = mem_addr - BASE_ADDR;
   assign idx       = offset[ADDR_WIDTH+1:2];
   assign in_range  = (offset[31:ADDR_WIDTH+2] == '0);
   assign is_read   = (mem_wstrb == '0);
   assign is_full   = (mem_wstrb == '1);
   assign reject    = !in_range || (!is_read && READ_ONLY);
   assign sram_addr = SRAM_AW'(idx);
   assign unused_ok = &{1'b0, mem_instr, offset[1:0]};

   always_comb begin
      merged = sram_dout;
      for (int k = 0; k < DATA_WIDTH/8; k++) begin
         if (mem_wstrb[k]) merged[8*k +: 8] = mem_wdata[8*k +: 8];
      end
   end

   always_comb begin
      state_d  = state_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      sram_csb = 1'b1;
      sram_web = 1'b1;
      sram_din = mem_wdata;
      case (state_q)
         S_IDLE: begin
            if (mem_valid) begin
               if (reject) begin
                  err_d   = 1'b1;
                  if (is_read) rdata_d = '0;
                  state_d = S_DONE;
               end else if (is_read) begin
                  sram_csb = 1'b0;
                  state_d  = S_RD;
               end else if (is_full) begin
                  sram_csb = 1'b0;
                  sram_web = 1'b0;
                  state_d  = S_DONE;
               end else begin
                  sram_csb = 1'b0;
                  state_d  = S_RMW;
               end
            end
         end
         S_RD: begin
            rdata_d = sram_dout;
            state_d = S_DONE;
         end
         S_RMW: begin
            sram_csb = 1'b0;
            sram_web = 1'b0;
            sram_din = merged;
            state_d  = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Reset must also kill an in-flight RMW write-back in the same cycle.
      if (!resetn) begin
         sram_csb = 1'b1;
         sram_web = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign mem_ready = (state_q == S_DONE);
   assign mem_rdata = rdata_q;
   assign err       = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized bench for mem_responder against a transaction-level model
// Two instances: a writable data RAM and a READ_ONLY instruction RAM, each with its own SRAM model.
module tb_mem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        resetn = 1'b0, mem_valid = 1'b0, mem_instr = 1'b0, r_valid = 1'b0;
   logic [31:0] mem_addr = '0, mem_wdata = '0;
   logic [3:0]  mem_wstrb = '0;
   logic        mem_ready, err, sram_csb, sram_web;
   logic [31:0] mem_rdata, sram_din, sram_dout;
   logic [5:0]  sram_addr;
   logic        r_ready, r_err, r_csb, r_web;
   logic [31:0] r_rdata, r_din, r_dout;
   logic [5:0]  r_saddr;

   mem_responder dut (
      .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_instr(mem_instr),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .err(err),
      .sram_csb(sram_csb), .sram_web(sram_web), .sram_addr(sram_addr),
      .sram_din(sram_din), .sram_dout(sram_dout)
   );

   mem_responder #(.READ_ONLY(1'b1)) dut_ro (
      .clk(clk), .resetn(resetn), .mem_valid(r_valid), .mem_instr(mem_instr),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_ready(r_ready), .mem_rdata(r_rdata), .err(r_err),
      .sram_csb(r_csb), .sram_web(r_web), .sram_addr(r_saddr),
      .sram_din(r_din), .sram_dout(r_dout)
   );

   // SRAM macro models with a preload port used only while the responders are idle
   logic [31:0] smem [64];
   logic [31:0] rmem [64];
   logic        pl_en = 1'b0;
   logic [5:0]  pl_a = '0;
   logic [31:0] pl_d = '0, pl_r = '0;
   int          csb_tot = 0, web_tot = 0, rweb_tot = 0;

   always @(posedge clk) begin
      if (pl_en) begin
         smem[pl_a] <= pl_d;
         rmem[pl_a] <= pl_r;
      end else begin
         if (!sram_csb) begin
            if (!sram_web) smem[sram_addr] <= sram_din;
            else           sram_dout <= smem[sram_addr];
         end
         if (!r_csb) begin
            if (!r_web) rmem[r_saddr] <= r_din;
            else        r_dout <= rmem[r_saddr];
         end
      end
   end

   always @(posedge clk) begin
      if (!sram_csb)             csb_tot  <= csb_tot + 1;
      if (!sram_csb && !sram_web) web_tot  <= web_tot + 1;
      if (!r_csb && !r_web)       rweb_tot <= rweb_tot + 1;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0, bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Architectural model: word contents, and the before/after view of rdata/err around exp_done
   logic [31:0] ref_mem [32];
   bit          chk_en = 1'b0;
   int          exp_done = -100;
   logic [31:0] rd_old = '0, rd_new = '0;
   logic        err_old = 1'b0, err_new = 1'b0;
   int          ready_cnt = 0, last_csb = 0, last_web = 0;

   always @(negedge clk) begin
      if (mem_ready) ready_cnt++;
      if (chk_en) begin
         chk("ready", 32'(mem_ready), 32'(cyc == exp_done));
         chk("rdata", mem_rdata, (cyc >= exp_done) ? rd_new : rd_old);
         chk("err", 32'(err), 32'((cyc >= exp_done) ? err_new : err_old));
      end
   end

   task automatic idle(input int k);
      repeat (k) begin
         @(negedge clk);
         #1;
      end
   endtask

   // Called just after a falling edge; returns just after the falling edge of the completion cycle.
   task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input bit hold);
      int          n, acc, lat, ecsb, eweb, c0, w0;
      logic [4:0]  idx;
      logic [31:0] m;
      n  = cyc;
      c0 = csb_tot;
      w0 = web_tot;
      mem_valid = 1'b1;
      mem_addr  = a;
      mem_wdata = d;
      mem_wstrb = s;
      mem_instr = 1'($urandom_range(0, 1));
      acc = (n == exp_done) ? n + 1 : n;
      idx = a[6:2];
      rd_old  = rd_new;
      err_old = err_new;
      if (a[31:7] != 0) begin
         lat = 1; ecsb = 0; eweb = 0;
         err_new = 1'b1;
         if (s == 0) rd_new = '0;
      end else if (s == 0) begin
         lat = 2; ecsb = 1; eweb = 0;
         rd_new = ref_mem[idx];
      end else begin
         m = ref_mem[idx];
         for (int k = 0; k < 4; k++) if (s[k]) m[8*k +: 8] = d[8*k +: 8];
         ref_mem[idx] = m;
         lat  = (s == 4'hF) ? 1 : 2;
         ecsb = lat;
         eweb = 1;
      end
      exp_done = acc + lat;
      do begin
         @(negedge clk);
         #1;
      end while (cyc < exp_done);
      last_csb = csb_tot - c0;
      last_web = web_tot - w0;
      chk("csb_count", last_csb, ecsb);
      chk("web_count", last_web, eweb);
      if (!hold) mem_valid = 1'b0;
   endtask

   task automatic ro_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         output int lat, output int webs);
      int w0;
      w0 = rweb_tot;
      r_valid = 1'b1;
      mem_addr = a;
      mem_wdata = d;
      mem_wstrb = s;
      lat = 0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (r_ready) begin
            lat = k;
            break;
         end
      end
      #1;
      r_valid = 1'b0;
      webs = rweb_tot - w0;
   endtask

   initial begin
      int          n0, c0, r0, lat, webs;
      logic [31:0] a;
      logic [3:0]  s;
      bit          hold;

      @(negedge clk);
      #1;
      pl_en = 1'b1;
      for (int i = 0; i < 64; i++) begin
         pl_a = 6'(i);
         pl_d = (i == 4) ? 32'h1122_3344 : (i == 5) ? 32'h5566_7788 : $urandom;
         pl_r = (i == 1) ? 32'hCAFE_F00D : $urandom;
         if (i < 32) ref_mem[i] = pl_d;
         @(negedge clk);
         #1;
      end
      pl_en = 1'b0;

      chk("rst_ready", 32'(mem_ready), 32'd0);
      chk("rst_rdata", mem_rdata, 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_csb", 32'(sram_csb), 32'd1);
      chk("rst_ro_err", 32'(r_err), 32'd0);
      resetn = 1'b1;
      chk_en = 1'b1;
      idle(1);

      n0 = cyc;
      req(32'h0C, 32'hDEAD_BEEF, 4'hF, 1'b0);
      chk("wr_latency", cyc - n0, 1);
      idle(1);
      n0 = cyc;
      req(32'h0C, 32'h0, 4'h0, 1'b0);
      chk("rd_latency", cyc - n0, 2);
      chk("rd_deadbeef", mem_rdata, 32'hDEAD_BEEF);
      chk("rd_err0", 32'(err), 32'd0);

      idle(1);
      req(32'h10, 32'hAABB_CCDD, 4'b0101, 1'b0);
      chk("merge_web_once", last_web, 1);
      idle(1);
      req(32'h10, 32'h0, 4'h0, 1'b0);
      chk("merge_rd", mem_rdata, 32'h11BB_33DD);

      idle(1);
      n0 = cyc;
      c0 = csb_tot;
      req(32'h80, 32'h0, 4'h0, 1'b0);
      chk("oor_latency", cyc - n0, 1);
      chk("oor_rdata", mem_rdata, 32'd0);
      chk("oor_err", 32'(err), 32'd1);
      chk("oor_csb_idle", csb_tot - c0, 0);
      idle(1);
      req(32'h0C, 32'h0, 4'h0, 1'b0);
      chk("post_oor_rd", mem_rdata, 32'hDEAD_BEEF);
      chk("post_oor_err", 32'(err), 32'd1);

      idle(1);
      ro_req(32'h04, 32'h1234_5678, 4'hF, lat, webs);
      chk("ro_wr_latency", lat, 1);
      chk("ro_err", 32'(r_err), 32'd1);
      chk("ro_no_write", webs, 0);
      idle(1);
      ro_req(32'h04, 32'h0, 4'h0, lat, webs);
      chk("ro_rd_latency", lat, 2);
      chk("ro_rd_data", r_rdata, 32'hCAFE_F00D);

      idle(1);
      n0 = cyc;
      c0 = csb_tot;
      r0 = ready_cnt;
      for (int i = 0; i < 8; i++) req(32'(4 * i), 32'h0, 4'h0, i != 7);
      chk("b2b_cycles", cyc - n0, 23);
      chk("b2b_pulses", ready_cnt - r0, 8);
      chk("b2b_accesses", csb_tot - c0, 8);

      idle(1);
      chk_en = 1'b0;
      mem_valid = 1'b1;
      mem_addr  = 32'h14;
      mem_wdata = 32'hA5A5_A5A5;
      mem_wstrb = 4'b0001;
      idle(1);
      resetn = 1'b0;
      #1;
      chk("rmw_rst_web", 32'(sram_web), 32'd1);
      chk("rmw_rst_csb", 32'(sram_csb), 32'd1);
      @(negedge clk);
      #1;
      mem_valid = 1'b0;
      chk("rmw_rst_word", smem[5], 32'h5566_7788);
      chk("rmw_rst_ready", 32'(mem_ready), 32'd0);
      chk("rmw_rst_err", 32'(err), 32'd0);
      chk("rmw_rst_rdata", mem_rdata, 32'd0);
      idle(1);
      resetn   = 1'b1;
      exp_done = -100;
      rd_old = '0; rd_new = '0;
      err_old = 1'b0; err_new = 1'b0;
      chk_en = 1'b1;
      idle(1);
      n0 = cyc;
      req(32'h14, 32'h0, 4'h0, 1'b0);
      chk("post_rst_latency", cyc - n0, 2);
      chk("post_rst_rd", mem_rdata, 32'h5566_7788);

      for (int t = 0; t < 300; t++) begin
         if ($urandom_range(0, 9) == 0) begin
            a = $urandom;
            if (a[31:7] == 0) a[31] = 1'b1;
         end else begin
            a = $urandom_range(0, 127);
         end
         case ($urandom_range(0, 9))
            0, 1, 2, 3: s = 4'h0;
            4, 5:       s = 4'hF;
            default:    s = 4'($urandom);
         endcase
         hold = 1'($urandom_range(0, 1));
         req(a, $urandom, s, hold);
         if (!hold) idle($urandom_range(0, 2));
      end
      mem_valid = 1'b0;
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
